sys_ctrl_tx: RTL and testbench
==============================

// Module: sys_ctrl_tx
// PURPOSE
//  Response side of the system controller. Captures read data from the register file and results from the ALU.
//  Serialises each response into byte frames for the UART transmitter using a valid/busy handshake.
//  Sits between REG_FILE/ALU and UART_TX. Mirrors the command decoder that drives WrEn/RdEn/ALU_EN.
// PARAMETERS
//  TX_FRAME_WIDTH  8   UART frame width in bits; width of TX_P_DATA and RdData
//  ALU_OUT_WIDTH   16  ALU result width; must be an integer multiple of TX_FRAME_WIDTH
// PORTS
//  CLK          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  RdData       in   TX_FRAME_WIDTH  register-file read data
//  RdData_VLD   in   1               1-cycle pulse: RdData valid
//  ALU_OUT      in   ALU_OUT_WIDTH   ALU result
//  ALU_OUT_VLD  in   1               1-cycle pulse: ALU_OUT valid
//  TX_Busy      in   1               UART_TX shifting a frame
//  TX_P_DATA    out  TX_FRAME_WIDTH  byte presented to UART_TX
//  TX_D_VLD     out  1               TX_P_DATA valid
//  Resp_Busy    out  1               response held or being sent; the command side must not issue RdEn/ALU_EN while high
//  Drop_Err     out  1               1-cycle pulse: a response was discarded
// BEHAVIOUR
//  Clock, reset and outputs:
//   - Single clock CLK. Asynchronous active-low reset rst_n.
//   - All outputs are registered. Reset values: TX_P_DATA=0, TX_D_VLD=0, Resp_Busy=0, Drop_Err=0.
//   - Reset also clears the state to IDLE, the holding register and the byte counter.
//  Holding register:
//   - One entry: data[ALU_OUT_WIDTH-1:0] and nbytes.
//   - A read is stored zero-extended with nbytes=1.
//   - An ALU result is stored with nbytes=ALU_OUT_WIDTH/TX_FRAME_WIDTH.
//   - Capture happens only in IDLE.
//  Simultaneous pulses:
//   - If RdData_VLD and ALU_OUT_VLD arrive in the same IDLE cycle, ALU_OUT is captured.
//   - The read is dropped and Drop_Err pulses on the next cycle.
//  Pulses while not IDLE:
//   - Any VLD pulse arriving outside IDLE is dropped, and Drop_Err pulses on the next cycle.
//   - The frame in flight is unaffected.
//  Handshake:
//   - A byte transfers in the cycle where TX_D_VLD=1 and TX_Busy=0.
//   - TX_D_VLD and TX_P_DATA stay stable until that transfer.
//   - After the transfer, TX_D_VLD drops the next cycle and stays low until TX_Busy has been seen high and then low.
//   - This guarantees exactly one frame per byte.
//  Byte order: byte 0 is data[TX_FRAME_WIDTH-1:0], i.e. least-significant byte first.
//  FSM states:
//   - IDLE: VLD pulse -> capture, Resp_Busy<=1, byte index<=0, go to SEND.
//   - SEND: TX_D_VLD=1, TX_P_DATA=current byte. On transfer -> WAIT_ACK.
//   - WAIT_ACK: TX_D_VLD=0. On TX_Busy=1 -> WAIT_DONE.
//   - WAIT_DONE: On TX_Busy=0, if index+1<nbytes -> increment index, go to SEND.
//   - WAIT_DONE: Otherwise -> Resp_Busy<=0, go to IDLE.
//   - Unused encodings -> IDLE.
//  Latency: a VLD pulse in cycle N gives TX_D_VLD=1 in cycle N+1.
//  Back-to-back responses:
//   - Resp_Busy falls on the same edge the FSM enters IDLE.
//   - A pulse in the first IDLE cycle is accepted.
//  TX_Busy stuck high: the FSM waits indefinitely in WAIT_DONE. There is no timeout.
//  Reset mid-frame: TX_D_VLD drops immediately. The partial response is lost and no Drop_Err is raised.
// STRUCTURE
//  - Shared package/header holds the state encodings (IDLE, SEND, WAIT_ACK, WAIT_DONE; 2-bit) and the frame constants.
//  - Frame constants in the package: RD_NBYTES=1, ALU_NBYTES.
//  - Single module with no sub-module. The byte select is an indexed part-select of the holding register.
// TESTING
//  1. RdData=8'h5A pulse, TX_Busy model (1 cycle after transfer, 10 cycles) -> one frame 8'h5A; TX_D_VLD high 1 cycle after pulse; Resp_Busy low after TX_Busy falls.
//  2. ALU_OUT=16'hBEEF pulse -> frames 8'hEF then 8'hBE; TX_D_VLD low between frames until TX_Busy high->low.
//  3. RdData_VLD and ALU_OUT_VLD together (8'h11, 16'h2233) -> frames 8'h33, 8'h22 only; Drop_Err one pulse.
//  4. RdData_VLD pulse during the ALU frame 2 -> Drop_Err pulse; ALU frames intact; no extra frame.
//  5. TX_Busy held high 5 cycles before an ALU pulse -> TX_D_VLD stays 1 with 8'hEF stable until TX_Busy=0.
//  6. rst_n asserted in WAIT_ACK of byte 0 -> all outputs 0 immediately; a new RdData=8'hC3 after release sends 8'hC3 only.

Source files
------------

// File: rtl/sys_ctrl_tx_pkg.sv
// Shared state encodings and frame constants for the system-controller response path.
package sys_ctrl_tx_pkg;

    localparam int TX_FRAME_W = 8;
    localparam int ALU_OUT_W  = 16;
    localparam int RD_NBYTES  = 1;
    localparam int ALU_NBYTES = ALU_OUT_W / TX_FRAME_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sys_ctrl_tx.sv
// Captures register-file reads / ALU results and serialises them LSB-byte-first to UART_TX.
// Latency: VLD pulse in cycle N -> TX_D_VLD in cycle N+1; all outputs registered.
// Backpressure: byte held until TX_Busy=0; next byte only after TX_Busy seen high then low.
module sys_ctrl_tx
    import sys_ctrl_tx_pkg::*;
#(
    parameter int TX_FRAME_WIDTH = TX_FRAME_W,
    parameter int ALU_OUT_WIDTH  = ALU_OUT_W
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic [TX_FRAME_WIDTH-1:0] RdData,
    input  logic                      RdData_VLD,
    input  logic [ALU_OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    input  logic                      TX_Busy,
    output logic [TX_FRAME_WIDTH-1:0] TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic                      Resp_Busy,
    output logic                      Drop_Err
);

    localparam int NBYTES = ALU_OUT_WIDTH / TX_FRAME_WIDTH;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    state_t                    r_state, w_nxt_state;
    logic [ALU_OUT_WIDTH-1:0]  r_data, w_nxt_data;
    logic [CNT_W-1:0]          r_nbytes, w_nxt_nbytes;
    logic [CNT_W-1:0]          r_idx, w_nxt_idx;
    logic [TX_FRAME_WIDTH-1:0] r_tx_p_data, w_nxt_tx_p_data;
    logic                      r_tx_d_vld, w_nxt_tx_d_vld;
    logic                      r_resp_busy, w_nxt_resp_busy;
    logic                      r_drop_err, w_nxt_drop_err;
    logic [CNT_W-1:0]          w_idx_inc;
    logic                      w_any_vld;

    assign w_idx_inc = r_idx + CNT_W'(1);
    assign w_any_vld = RdData_VLD | ALU_OUT_VLD;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_nbytes    <= '0;
            r_idx       <= '0;
            r_tx_p_data <= '0;
            r_tx_d_vld  <= 1'b0;
            r_resp_busy <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_data      <= w_nxt_data;
            r_nbytes    <= w_nxt_nbytes;
            r_idx       <= w_nxt_idx;
            r_tx_p_data <= w_nxt_tx_p_data;
            r_tx_d_vld  <= w_nxt_tx_d_vld;
            r_resp_busy <= w_nxt_resp_busy;
            r_drop_err  <= w_nxt_drop_err;
        end
    end

    // Outputs are computed alongside the next state so they can be registered
    // and still meet the one-cycle pulse-to-TX_D_VLD latency.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_data      = r_data;
        w_nxt_nbytes    = r_nbytes;
        w_nxt_idx       = r_idx;
        w_nxt_tx_p_data = r_tx_p_data;
        w_nxt_tx_d_vld  = r_tx_d_vld;
        w_nxt_resp_busy = r_resp_busy;
        w_nxt_drop_err  = 1'b0;

        case (r_state)
            IDLE: begin
                if (ALU_OUT_VLD) begin
                    w_nxt_data      = ALU_OUT;
                    w_nxt_nbytes    = CNT_W'(NBYTES);
                    w_nxt_idx       = '0;
                    w_nxt_tx_p_data = ALU_OUT[TX_FRAME_WIDTH-1:0];
                    w_nxt_tx_d_vld  = 1'b1;
                    w_nxt_resp_busy = 1'b1;
                    w_nxt_drop_err  = RdData_VLD;
                    w_nxt_state     = SEND;
                end else if (RdData_VLD) begin
                    w_nxt_data      = ALU_OUT_WIDTH'(RdData);
                    w_nxt_nbytes    = CNT_W'(RD_NBYTES);
                    w_nxt_idx       = '0;
                    w_nxt_tx_p_data = RdData;
                    w_nxt_tx_d_vld  = 1'b1;
                    w_nxt_resp_busy = 1'b1;
                    w_nxt_state     = SEND;
                end
            end
            SEND: begin
                w_nxt_drop_err = w_any_vld;
                if (!TX_Busy) begin
                    w_nxt_tx_d_vld = 1'b0;
                    w_nxt_state    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                w_nxt_drop_err = w_any_vld;
                if (TX_Busy) begin
                    w_nxt_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                w_nxt_drop_err = w_any_vld;
                if (!TX_Busy) begin
                    if (w_idx_inc < r_nbytes) begin
                        w_nxt_idx       = w_idx_inc;
                        w_nxt_tx_p_data = r_data[w_idx_inc*TX_FRAME_WIDTH +: TX_FRAME_WIDTH];
                        w_nxt_tx_d_vld  = 1'b1;
                        w_nxt_state     = SEND;
                    end else begin
                        w_nxt_resp_busy = 1'b0;
                        w_nxt_state     = IDLE;
                    end
                end
            end
            default: begin
                w_nxt_tx_d_vld  = 1'b0;
                w_nxt_resp_busy = 1'b0;
                w_nxt_state     = IDLE;
            end
        endcase
    end

    assign TX_P_DATA = r_tx_p_data;
    assign TX_D_VLD  = r_tx_d_vld;
    assign Resp_Busy = r_resp_busy;
    assign Drop_Err  = r_drop_err;

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Self-checking bench for sys_ctrl_tx: byte-queue response model, UART_TX busy model, directed tests.
module tb_sys_ctrl_tx;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  RdData = '0;
    logic        RdData_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        TX_Busy = 1'b0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        Resp_Busy;
    logic        Drop_Err;

    sys_ctrl_tx #(.TX_FRAME_WIDTH(8), .ALU_OUT_WIDTH(16)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .RdData(RdData), .RdData_VLD(RdData_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_Busy(TX_Busy),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .Resp_Busy(Resp_Busy), .Drop_Err(Drop_Err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // UART_TX model: busy rises one cycle after a transfer and stays high 10 cycles.
    logic [7:0] rx_q[$];
    bit force_busy = 0;
    bit u_xfer = 0;
    bit u_start = 0;
    int u_cnt = 0;
    always begin
        @(posedge CLK);
        u_xfer = rst_n && TX_D_VLD && !TX_Busy;
        if (u_xfer) rx_q.push_back(TX_P_DATA);
        #1;
        if (u_cnt > 0) u_cnt--;
        if (u_start) begin
            u_cnt = 10;
            u_start = 0;
        end
        if (u_xfer) u_start = 1;
        TX_Busy = force_busy || (u_cnt > 0);
    end

    // Response model: a pending response is a queue of bytes; a byte is offered whenever
    // a response is pending and no frame is in progress.
    logic [7:0] m_q[$];
    bit m_busy = 0, m_drop = 0, m_frame = 0, m_seen = 0, m_offer = 0;

    function automatic bit m_vld();
        return m_busy && (m_q.size() != 0) && !m_frame;
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_busy = 0; m_drop = 0; m_frame = 0; m_seen = 0;
        end else begin
            m_offer = m_vld();
            m_drop = 0;
            if (!m_busy) begin
                if (ALU_OUT_VLD) begin
                    m_q.push_back(ALU_OUT[7:0]);
                    m_q.push_back(ALU_OUT[15:8]);
                    m_busy = 1;
                    m_drop = RdData_VLD;
                end else if (RdData_VLD) begin
                    m_q.push_back(RdData);
                    m_busy = 1;
                end
            end else begin
                m_drop = RdData_VLD || ALU_OUT_VLD;
                if (m_offer && !TX_Busy) begin
                    void'(m_q.pop_front());
                    m_frame = 1;
                    m_seen = 0;
                end else if (m_frame && TX_Busy) begin
                    m_seen = 1;
                end else if (m_frame && m_seen && !TX_Busy) begin
                    m_frame = 0;
                    if (m_q.size() == 0) m_busy = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (rst_n) begin
            check("resp_busy", Resp_Busy, m_busy);
            check("drop_err", Drop_Err, m_drop);
            check("tx_d_vld", TX_D_VLD, m_vld());
            if (m_vld()) check("tx_p_data", TX_P_DATA, m_q[0]);
            if (Drop_Err) drop_cnt++;
        end
    end

    task automatic pulse(input bit rd, input bit alu, input logic [7:0] rd_d, input logic [15:0] alu_d);
        @(negedge CLK);
        RdData = rd_d; ALU_OUT = alu_d; RdData_VLD = rd; ALU_OUT_VLD = alu;
        @(negedge CLK);
        RdData_VLD = 0; ALU_OUT_VLD = 0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge CLK);
        while ((Resp_Busy || TX_Busy) && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 300) timeout(name);
        @(negedge CLK);
    endtask

    task automatic wait_rx(input int n, input string name);
        int k = 0;
        while (rx_q.size() < n && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 300) timeout(name);
    endtask

    int d0;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx_p_data", TX_P_DATA, 8'h00);
        check("rst_tx_d_vld", TX_D_VLD, 1'b0);
        check("rst_resp_busy", Resp_Busy, 1'b0);
        check("rst_drop_err", Drop_Err, 1'b0);
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);

        // 1: single read byte
        rx_q.delete(); d0 = drop_cnt;
        pulse(1, 0, 8'h5A, 16'h0);
        check("t1_vld_latency", TX_D_VLD, 1'b1);
        check("t1_busy_up", Resp_Busy, 1'b1);
        wait_idle("t1_idle");
        check("t1_nframes", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("t1_byte0", rx_q[0], 8'h5A);

        // 2: ALU result, LSB first
        rx_q.delete();
        pulse(0, 1, 8'h00, 16'hBEEF);
        wait_idle("t2_idle");
        check("t2_nframes", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("t2_byte0", rx_q[0], 8'hEF);
            check("t2_byte1", rx_q[1], 8'hBE);
        end

        // 3: simultaneous pulses, ALU wins
        rx_q.delete(); d0 = drop_cnt;
        pulse(1, 1, 8'h11, 16'h2233);
        wait_idle("t3_idle");
        check("t3_nframes", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("t3_byte0", rx_q[0], 8'h33);
            check("t3_byte1", rx_q[1], 8'h22);
        end
        check("t3_drops", drop_cnt - d0, 1);

        // 4: read pulse during second ALU frame is dropped
        rx_q.delete(); d0 = drop_cnt;
        pulse(0, 1, 8'h00, 16'hA55A);
        wait_rx(2, "t4_rx2");
        pulse(1, 0, 8'h77, 16'h0);
        wait_idle("t4_idle");
        check("t4_nframes", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("t4_byte0", rx_q[0], 8'h5A);
            check("t4_byte1", rx_q[1], 8'hA5);
        end
        check("t4_drops", drop_cnt - d0, 1);

        // 5: TX_Busy held high before the response
        rx_q.delete();
        @(negedge CLK); force_busy = 1;
        repeat (5) @(negedge CLK);
        pulse(0, 1, 8'h00, 16'hBEEF);
        repeat (3) @(negedge CLK);
        check("t5_vld_held", TX_D_VLD, 1'b1);
        check("t5_data_held", TX_P_DATA, 8'hEF);
        check("t5_no_xfer", rx_q.size(), 0);
        force_busy = 0;
        wait_idle("t5_idle");
        check("t5_nframes", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("t5_byte0", rx_q[0], 8'hEF);
            check("t5_byte1", rx_q[1], 8'hBE);
        end

        // 6: reset in WAIT_ACK of byte 0, then a fresh read
        rx_q.delete();
        pulse(0, 1, 8'h00, 16'h1234);
        wait_rx(1, "t6_rx1");
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_vld", TX_D_VLD, 1'b0);
        check("t6_rst_busy", Resp_Busy, 1'b0);
        check("t6_rst_data", TX_P_DATA, 8'h00);
        check("t6_rst_drop", Drop_Err, 1'b0);
        @(negedge CLK);
        rst_n = 1'b1;
        rx_q.delete(); d0 = drop_cnt;
        pulse(1, 0, 8'hC3, 16'h0);
        wait_idle("t6_idle");
        check("t6_nframes", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("t6_byte0", rx_q[0], 8'hC3);
        check("t6_drops", drop_cnt - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
